// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [15:0] if_instr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        m_en,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_done
);

  if (STARVE_MAX < 1) begin : g_bad_cfg
    $error("STARVE_MAX must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t state, state_nxt;
  logic   kill, kill_nxt;
  logic   fetch_pend, force_fetch;
  logic   grant_i, grant_d;

  // A fetch whose flush is asserted this cycle is not a candidate for grant.
  assign fetch_pend = if_req && !if_flush;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign force_fetch = fetch_pend && (starve_cnt == CW'(STARVE_MAX));

  // Counts data grants that overtook a waiting fetch; saturates at STARVE_MAX because the fetch wins there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         starve_cnt <= '0;
    else if (grant_i) starve_cnt <= '0;
    else if (grant_d) starve_cnt <= fetch_pend ? starve_cnt + CW'(1) : '0;
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !force_fetch) begin
          grant_d   = 1'b1;
          state_nxt = DBUSY;
        end else if (fetch_pend) begin
          grant_i   = 1'b1;
          state_nxt = IBUSY;
        end
      end
      IBUSY: begin
        kill_nxt = kill | if_flush;
        if (m_done) begin
          state_nxt = IDLE;
          kill_nxt  = 1'b0;
        end
      end
      DBUSY: if (m_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // m_wr stays at the granted value for the whole access and doubles as the write flag at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en     <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_instr <= '0;
      dm_rdata <= '0;
    end else begin
      m_en    <= grant_i | grant_d;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_d) begin
        m_wr    <= dm_wr;
        m_addr  <= dm_addr;
        m_wdata <= dm_wdata;
      end else if (grant_i) begin
        m_wr   <= 1'b0;
        m_addr <= if_addr;
      end
      // A flush landing in the same cycle as m_done still kills the fetch.
      if (state == IBUSY && m_done && !(kill || if_flush)) begin
        if_done  <= 1'b1;
        if_instr <= m_rdata;
      end
      if (state == DBUSY && m_done) begin
        dm_done <= 1'b1;
        if (!m_wr) dm_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, variable-latency 16-bit memory between the instruction-fetch stage (read-only) and the memory-access stage (read/write). It sits between the pipeline and the unified memory. It serialises accesses, latches the returned data, and generates per-requester done pulses that the pipeline converts into stalls. It also supports cancelling an in-flight fetch on a PC redirect.

## Interface
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before the fetch is forced through (≥1)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_done or if_flush
- if_addr  in  16  fetch address
- if_flush  in  1  cancel current/in-flight fetch (PC redirect)
- if_done  out  1  one-cycle pulse; if_instr valid
- if_instr  out  16  last fetched instruction (held)
- dm_req  in  1  data request; held with stable dm_addr/dm_wr/dm_wdata until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_done  out  1  one-cycle pulse; access complete, dm_rdata valid for reads
- dm_rdata  out  16  last read data (held)
- m_en  out  1  issue pulse to memory, exactly one cycle per access
- m_wr  out  1  write enable, valid with m_en
- m_addr  out  16  address, registered at grant, held for the whole access
- m_wdata  out  16  write data, registered at grant
- m_rdata  in  16  memory read data, valid with m_done
- m_done  in  1  memory completion pulse, ≥1 cycle after m_en

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE handling:
  - Sample requests each cycle. A requester with its flush asserted that cycle is ignored: if_req is disregarded when if_flush=1.
  - Grant rule: dm_req wins over if_req, unless the starvation guard forces the fetch.
  - On grant, latch address, write flag and data into m_*, and go to IBUSY or DBUSY.
- IBUSY/DBUSY handling:
  - m_en is high only in the first busy cycle.
  - Wait for m_done, then return to IDLE.
- Read completion: when m_done arrives for a read, latch m_rdata into if_instr or dm_rdata and pulse the matching done on the next cycle.
- Writes: pulse dm_done only; dm_rdata is unchanged.
- Flush:
  - if_flush in IBUSY sets a kill flag.
  - On m_done with kill set: no if_done, if_instr unchanged, kill cleared, return to IDLE.
  - if_flush in IDLE or DBUSY has no effect beyond the IDLE masking above.
  - if_flush has no effect on data accesses.
- Stray m_done: m_done in IDLE is ignored.
- No new grant before the current access's m_done; only one access is ever outstanding.
- Reset outputs (rst low): state IDLE, kill 0, starvation count 0, and all outputs 0 (if_done, dm_done, m_en, m_wr, m_addr, m_wdata, if_instr, dm_rdata).
- Reset mid-access: the in-flight access is abandoned. Its later m_done arrives in IDLE and is ignored.

## Timing
- Cycle 0: request seen in IDLE, grant registered.
- Cycle 1: m_en=1.
- Cycle k≥2: m_done.
- Cycle k+1: done pulse with data, state IDLE. A new grant can be made in this cycle, so the next m_en is at k+2.
- Minimum latency from request to done is 3 cycles; peak throughput is one access per 3 cycles.
- if_done and dm_done are never high in the same cycle.
- A requester may deassert its req in the cycle after its done pulse. If req is still high in the done cycle, it is treated as a new request.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - Counter, width clog2(STARVE_MAX+1), increments on each data grant made while if_req (unflushed) is pending.
  - When count==STARVE_MAX and both requesters are pending, the fetch is granted.
  - Count clears on any fetch grant, or on a data grant with no fetch pending.
- ARB_STARVE_GUARD_EN undefined: strict data priority and no counter logic. A fetch may wait indefinitely while dm_req stays high.

## Test plan
- Single fetch: if_req, if_addr=0x0010, memory returns 0xA5A5 with m_done 1 cycle after m_en -> m_en at cycle 1 with m_addr=0x0010, if_done at cycle 3, if_instr=0xA5A5.
- Simultaneous requests: if_req and dm_req (read 0x0200) together -> data served first, dm_done, then the fetch is issued 1 cycle later; if_done never overlaps dm_done.
- Write: dm_wr=1, dm_addr=0x0300, dm_wdata=0x1234 -> m_wr=1 with m_en, m_wdata=0x1234, dm_done pulses, dm_rdata unchanged.
- Flush in flight: if_flush during IBUSY, then m_done with 0xBEEF -> no if_done, if_instr keeps its old value, next fetch proceeds normally.
- Starvation (macro on, STARVE_MAX=4): dm_req and if_req held continuously -> fetch granted after exactly 4 data grants. Macro off -> no fetch grant over 20 data accesses.
- Reset during DBUSY, then a stray m_done after release -> all outputs 0, no done pulse, next request handled from IDLE.
